key_repeat_ctrl: RTL and testbench
==================================

Name: key_repeat_ctrl

Overview:
- Converts raw USB HID keycode slots from the MicroBlaze GPIO words into one-cycle game action pulses.
- Each action supports delayed auto-shift (DAS) and auto-repeat (ARR), timed in video frames.
- Sits between the keycode GPIO outputs and the game logic.
- Generalises single-keycode, level-sensitive control to N keycode slots, M actions, per-action repeat/one-shot mode, and left/right conflict resolution.

Parameters:
- NUM_SLOTS, 8, number of 8-bit keycode slots examined (two 32-bit GPIO words).
- NUM_ACTIONS, 6, number of action outputs; keycode and mode per action come from the package table.
- DAS_DELAY, 10, frames from first pulse to first repeat pulse; legal range 1..63.
- ARR_PERIOD, 2, frames between repeat pulses; legal range 1..63.
- CNT_W, 6, frame counter width.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- keycodes  in  NUM_SLOTS*8  packed HID keycodes; slot k = bits [8k+7:8k]; synchronous to clk.
- frame_sync  in  1  vsync from pixel-clock domain; asynchronous to clk.
- enable  in  1  high = game running; low = paused.
- action_pulse  out  NUM_ACTIONS  one-cycle strobe per action event.
- action_held  out  NUM_ACTIONS  level: action key currently held (post-arbitration).

Behaviour:
- Reset: all outputs 0, all FSMs IDLE, counters 0, synchroniser flops 0. Reset is asserted asynchronously; deassertion is taken on the clk edge.
- Frame tick:
  - frame_sync passes through a 2-flop synchroniser, then a rising-edge detect.
  - tick = 1-cycle pulse; latency is 3 clk cycles from the vsync rise.
- Key detect:
  - keycodes registered once (stage 1).
  - raw_held[a] = any slot equals ACT_KEY[a]; keycode 0x00 never matches.
  - Rollover: if any slot = 0x01 (ErrorRollOver), raw_held holds its previous value for that cycle.
- Left/right arbitration (actions 0 and 1):
  - If both are held, only the most recently newly-held one is held.
  - If both become newly held in the same cycle, action 0 wins.
  - When the winner is released, the other becomes held, restarts at PRESS, and issues a fresh pulse.
- Per-action FSM (stage 2), states IDLE, PRESS, DELAY, REPEAT, LATCHED:
  - IDLE -> PRESS when held. action_pulse is asserted for exactly one cycle, 2 clk edges after the keycode change (stage-1 register plus FSM register).
  - PRESS -> DELAY (REPEAT-mode action), counter = DAS_DELAY. PRESS -> LATCHED (ONESHOT-mode action).
  - DELAY: counter decrements on each tick. A tick that brings the counter to 0 emits a pulse, reloads ARR_PERIOD, and moves to REPEAT.
  - REPEAT: on counter expiry, emit a pulse and reload ARR_PERIOD.
  - LATCHED: no further pulses.
  - Any state -> IDLE on release, same cycle as held falls. Counter clears; no pulse on release.
  - A release and an expiring tick in the same cycle: release wins, no pulse.
- enable low:
  - All FSMs forced to IDLE; action_pulse and action_held forced to 0.
  - Keys still held when enable rises are treated as new presses and pulse on the next cycle.
- action_held is registered and equals the FSM state != IDLE.
- Counters saturate at 0; no wrap.

Decomposition:
- Package key_pkg:
  - action index constants ACT_LEFT=0, ACT_RIGHT=1, ACT_DROP=2, ACT_ROT=3, ACT_HARD=4, ACT_HOLD=5.
  - ACT_KEY table: 0x04 (A), 0x07 (D), 0x16 (S), 0x1A (W), 0x2C (space), 0x14 (Q).
  - typedef act_mode_e {REPEAT, ONESHOT}; ACT_MODE table: REPEAT for actions 0..2, ONESHOT for 3..5.
  - typedef key_state_e for the FSM states.
- Sub-module key_repeat_fsm: one instance per action via generate. Inputs: held, tick, enable, mode. Outputs: pulse, held_out.

Test Plan:
- Reset + idle: reset_n=0 with keycodes=0x04 -> all outputs 0. After release and no tick -> exactly one pulse on action_pulse[0] 2 cycles after release; action_held[0]=1.
- DAS/ARR: hold 0x04, DAS=10, ARR=2, 20 ticks -> pulses at press and at ticks 10, 12, 14, 16, 18, 20 (7 total). Release -> no further pulses.
- One-shot: hold 0x1A in slot 5 for 30 ticks -> exactly one action_pulse[3]. Release and repress -> a second pulse.
- Conflict: hold 0x04, then add 0x07 in another slot -> pulse[1], held=2'b10. Drop 0x07 -> pulse[0], held=2'b01. Both pressed in the same cycle -> only pulse[0].
- Rollover/edge cases: slot 0x01 while 0x07 was held -> held persists, no spurious pulse. Release coincident with expiring tick -> no pulse. enable=0 mid-REPEAT -> outputs 0; enable=1 with key held -> immediate new pulse.
- Async reset mid-operation: assert reset_n=0 in REPEAT between clk edges -> outputs 0 immediately. Deassert with key held -> fresh press pulse.

Source files
------------

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the keyboard-to-game-action path: action indices,
// the HID keycode bound to each action, the per-action repeat behaviour and
// the state encoding of the per-action repeat FSM.
// Ports: none (package).
// ---------------------------------------------------------------------------
package key_pkg;

  // Action indices as seen on action_pulse / action_held
  localparam int ACT_LEFT  = 0;
  localparam int ACT_RIGHT = 1;
  localparam int ACT_DROP  = 2;
  localparam int ACT_ROT   = 3;
  localparam int ACT_HARD  = 4;
  localparam int ACT_HOLD  = 5;

  localparam int NUM_TABLE_ACTIONS = 6;

  // HID "no key" and ErrorRollOver codes
  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  // Keycode per action, index 0 on the right: A, D, S, W, space, Q
  localparam logic [NUM_TABLE_ACTIONS-1:0][7:0] ACT_KEY =
    {8'h14, 8'h2C, 8'h1A, 8'h16, 8'h07, 8'h04};

  typedef enum logic {
    REPEAT  = 1'b0,
    ONESHOT = 1'b1
  } act_mode_e;

  // Movement and soft drop auto-repeat; rotate, hard drop and hold fire once
  localparam act_mode_e ACT_MODE [NUM_TABLE_ACTIONS] =
    '{REPEAT, REPEAT, REPEAT, ONESHOT, ONESHOT, ONESHOT};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_DELAY   = 3'd2,
    S_REPEAT  = 3'd3,
    S_LATCHED = 3'd4
  } key_state_e;

  // Actions beyond the table get keycode 0x00, which never matches a slot
  function automatic logic [7:0] actKey(input int a);
    if (a >= 0 && a < NUM_TABLE_ACTIONS) return ACT_KEY[a];
    return KEY_NONE;
  endfunction

  // Actions beyond the table default to one-shot
  function automatic act_mode_e actMode(input int a);
    if (a >= 0 && a < NUM_TABLE_ACTIONS) return ACT_MODE[a];
    return ONESHOT;
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// ---------------------------------------------------------------------------
// key_repeat_fsm
// Per-action press / delayed-auto-shift / auto-repeat sequencer. Emits a
// one-cycle pulse on press, then (in REPEAT mode) a pulse after DAS_DELAY
// frame ticks and every ARR_PERIOD ticks after that while the key stays held.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   held          arbitrated key-held level for this action
//   tick          one-cycle frame tick
//   enable        game running; low forces IDLE
//   mode          REPEAT or ONESHOT
//   pulse         one-cycle action strobe (registered)
//   held_out      high whenever the FSM is not IDLE (registered state)
// ---------------------------------------------------------------------------
module key_repeat_fsm
  import key_pkg::*;
#(
  parameter int DAS_DELAY  = 10,
  parameter int ARR_PERIOD = 2,
  parameter int CNT_W      = 6
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      held,
  input  logic      tick,
  input  logic      enable,
  input  act_mode_e mode,
  output logic      pulse,
  output logic      held_out
);

  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // State, frame counter and the pulse strobe are all registered so the
  // outputs are glitch-free and clear immediately on asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. Release (or pause) is checked first so that it wins
  // over a tick that would otherwise expire the counter in the same cycle.
  // A counter already at zero counts as expired, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!enable || !held) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PRESS;
          pulse_d = 1'b1;
        end
        S_PRESS: begin
          if (mode == REPEAT) begin
            state_d = S_DELAY;
            cnt_d   = DAS_LOAD;
          end else begin
            state_d = S_LATCHED;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (tick) begin
            if (cnt_q <= CNT_ONE) begin
              state_d = S_REPEAT;
              cnt_d   = ARR_LOAD;
              pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        S_LATCHED: begin
          state_d = S_LATCHED;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pulse    = pulse_q;
  assign held_out = (state_q != S_IDLE);

endmodule

// File: rtl/key_repeat_ctrl.sv
// ---------------------------------------------------------------------------
// key_repeat_ctrl
// Turns raw HID keycode slots into per-action game pulses with delayed
// auto-shift and auto-repeat measured in video frames.
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   keycodes      NUM_SLOTS packed 8-bit HID keycodes, slot k = [8k+7:8k]
//   frame_sync    vsync from the pixel clock domain (asynchronous)
//   enable        high while the game runs; low pauses all actions
//   action_pulse  one-cycle strobe per action event
//   action_held   action currently held after left/right arbitration
// ---------------------------------------------------------------------------
module key_repeat_ctrl
  import key_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int NUM_ACTIONS = 6,
  parameter int DAS_DELAY   = 10,
  parameter int ARR_PERIOD  = 2,
  parameter int CNT_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SLOTS*8-1:0] keycodes,
  input  logic                   frame_sync,
  input  logic                   enable,
  output logic [NUM_ACTIONS-1:0] action_pulse,
  output logic [NUM_ACTIONS-1:0] action_held
);

  logic [NUM_SLOTS*8-1:0] keys_q;
  logic                   syncMeta_q, syncStable_q, syncPrev_q, tick_q;
  logic [NUM_ACTIONS-1:0] keyMatch, rawHeld, rawHeld_q, newHeld, arbHeld;
  logic                   rollover;
  logic                   rightWins_q, rightWins_d;

  // Two-flop synchroniser on vsync, then a registered rising-edge detect.
  // The tick appears three clk cycles after vsync rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta_q   <= 1'b0;
      syncStable_q <= 1'b0;
      syncPrev_q   <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      syncMeta_q   <= frame_sync;
      syncStable_q <= syncMeta_q;
      syncPrev_q   <= syncStable_q;
      tick_q       <= syncStable_q & ~syncPrev_q;
    end
  end

  // Stage 1: register the keycode slots, remember last cycle's held vector
  // (needed for rollover and new-press detection) and the left/right winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_q      <= '0;
      rawHeld_q   <= '0;
      rightWins_q <= 1'b0;
    end else begin
      keys_q      <= keycodes;
      rawHeld_q   <= rawHeld;
      rightWins_q <= rightWins_d;
    end
  end

  // Slot matching. An empty slot (0x00) never matches anything. Any slot
  // reporting ErrorRollOver means the report is untrustworthy, so the held
  // vector is frozen at its previous value for that cycle.
  always_comb begin
    keyMatch = '0;
    rollover = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (keys_q[8*s +: 8] == KEY_ROLLOVER) rollover = 1'b1;
      for (int a = 0; a < NUM_ACTIONS; a++) begin
        if (keys_q[8*s +: 8] != KEY_NONE && keys_q[8*s +: 8] == actKey(a)) begin
          keyMatch[a] = 1'b1;
        end
      end
    end
    rawHeld = rollover ? rawHeld_q : keyMatch;
    newHeld = rawHeld & ~rawHeld_q;
  end

  // Left/right arbitration: the most recent new press wins, left wins a tie.
  // When the winner is released the loser's FSM sees held rise from IDLE and
  // therefore starts over with a fresh press pulse.
  always_comb begin
    rightWins_d = rightWins_q;
    if (newHeld[ACT_LEFT]) begin
      rightWins_d = 1'b0;
    end else if (newHeld[ACT_RIGHT]) begin
      rightWins_d = 1'b1;
    end
    arbHeld            = rawHeld;
    arbHeld[ACT_LEFT]  = rawHeld[ACT_LEFT]  & ~(rawHeld[ACT_RIGHT] &  rightWins_d);
    arbHeld[ACT_RIGHT] = rawHeld[ACT_RIGHT] & ~(rawHeld[ACT_LEFT]  & ~rightWins_d);
  end

  // Stage 2: one sequencer per action
  for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_act
    key_repeat_fsm #(
      .DAS_DELAY  (DAS_DELAY),
      .ARR_PERIOD (ARR_PERIOD),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk      (clk),
      .reset_n  (reset_n),
      .held     (arbHeld[a]),
      .tick     (tick_q),
      .enable   (enable),
      .mode     (actMode(a)),
      .pulse    (action_pulse[a]),
      .held_out (action_held[a])
    );
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_repeat_ctrl
// Directed self-checking bench for key_repeat_ctrl with default parameters
// (8 slots, 6 actions, DAS 10 frames, ARR 2 frames).
// ---------------------------------------------------------------------------
module tb_key_repeat_ctrl;

  logic        clk;
  logic        reset_n;
  logic [63:0] keycodes;
  logic        frame_sync;
  logic        enable;
  logic [5:0]  action_pulse;
  logic [5:0]  action_held;

  int checks = 0;
  int errors = 0;
  int pulseTotal [6] = '{default: 0};

  key_repeat_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .keycodes     (keycodes),
    .frame_sync   (frame_sync),
    .enable       (enable),
    .action_pulse (action_pulse),
    .action_held  (action_held)
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Running count of observed pulses per action, sampled on the falling edge
  always @(negedge clk) begin
    for (int a = 0; a < 6; a++) begin
      if (action_pulse[a] === 1'b1) pulseTotal[a] <= pulseTotal[a] + 1;
    end
  end

  // Advance n cycles; returns 1 ns after a falling edge, well away from the
  // rising edge, which is where inputs are driven and outputs sampled.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] keys);
    keycodes = keys;
  endtask

  // One vsync pulse: the tick is consumed by the FSMs on the 4th rising edge
  task automatic frameTick();
    frame_sync = 1'b1;
    waitCycles(4);
    frame_sync = 1'b0;
    waitCycles(4);
  endtask

  task automatic releaseAll();
    applyStimulus(64'h0);
    waitCycles(4);
  endtask

  task automatic test_reset();
    int base;
    reset_n    = 1'b0;
    enable     = 1'b1;
    frame_sync = 1'b0;
    applyStimulus(64'h04);
    waitCycles(3);
    checks++;
    if (action_pulse !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_pulse actual=%b expected=%b", action_pulse, 6'b0);
    end
    checks++;
    if (action_held !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_held actual=%b expected=%b", action_held, 6'b0);
    end
    base    = pulseTotal[0];
    reset_n = 1'b1;
    waitCycles(1);
    checks++;
    if (action_pulse !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_edge_pulse actual=%b expected=%b", action_pulse, 6'b0);
    end
    waitCycles(1);
    checks++;
    if (action_pulse !== 6'b000001 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_press pulse=%b held=%b expected %b/%b",
               action_pulse, action_held, 6'b000001, 6'b000001);
    end
    waitCycles(3);
    checks++;
    if (pulseTotal[0] - base !== 1 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL reset_single_pulse count=%0d held=%b expected 1/%b",
               pulseTotal[0] - base, action_held, 6'b000001);
    end
    releaseAll();
  endtask

  task automatic test_das_arr();
    int base;
    int expected;
    base = pulseTotal[0];
    applyStimulus(64'h04);
    waitCycles(3);
    checks++;
    if (pulseTotal[0] - base !== 1) begin
      errors++;
      $display("[TB] FAIL das_press count=%0d expected=1", pulseTotal[0] - base);
    end
    for (int t = 1; t <= 20; t++) begin
      frameTick();
      expected = 1 + ((t >= 10) ? 1 + (t - 10) / 2 : 0);
      if (t == 9 || t == 10 || t == 11 || t == 12 || t == 20) begin
        checks++;
        if (pulseTotal[0] - base !== expected) begin
          errors++;
          $display("[TB] FAIL das_tick%0d count=%0d expected=%0d", t, pulseTotal[0] - base, expected);
        end
      end
    end
    applyStimulus(64'h0);
    waitCycles(2);
    checks++;
    if (action_held !== 6'b0) begin
      errors++;
      $display("[TB] FAIL das_release_held actual=%b expected=%b", action_held, 6'b0);
    end
    frameTick();
    frameTick();
    checks++;
    if (pulseTotal[0] - base !== 7) begin
      errors++;
      $display("[TB] FAIL das_after_release count=%0d expected=7", pulseTotal[0] - base);
    end
    releaseAll();
  endtask

  task automatic test_oneshot();
    int base;
    int baseLeft;
    base     = pulseTotal[3];
    baseLeft = pulseTotal[0];
    applyStimulus(64'h0000_1A00_0000_0000);
    waitCycles(3);
    for (int t = 0; t < 30; t++) frameTick();
    checks++;
    if (pulseTotal[3] - base !== 1 || action_held !== 6'b001000) begin
      errors++;
      $display("[TB] FAIL oneshot_hold count=%0d held=%b expected 1/%b",
               pulseTotal[3] - base, action_held, 6'b001000);
    end
    checks++;
    if (pulseTotal[0] - baseLeft !== 0) begin
      errors++;
      $display("[TB] FAIL oneshot_other count=%0d expected=0", pulseTotal[0] - baseLeft);
    end
    applyStimulus(64'h0);
    waitCycles(3);
    applyStimulus(64'h0000_1A00_0000_0000);
    waitCycles(3);
    checks++;
    if (pulseTotal[3] - base !== 2) begin
      errors++;
      $display("[TB] FAIL oneshot_repress count=%0d expected=2", pulseTotal[3] - base);
    end
    releaseAll();
  endtask

  task automatic test_conflict();
    int baseRight;
    applyStimulus(64'h04);
    waitCycles(3);
    checks++;
    if (action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL conflict_left_held actual=%b expected=%b", action_held, 6'b000001);
    end
    applyStimulus(64'h0000_0000_0007_0004);
    waitCycles(2);
    checks++;
    if (action_pulse !== 6'b000010 || action_held !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL conflict_right_wins pulse=%b held=%b expected %b/%b",
               action_pulse, action_held, 6'b000010, 6'b000010);
    end
    applyStimulus(64'h04);
    waitCycles(2);
    checks++;
    if (action_pulse !== 6'b000001 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL conflict_left_returns pulse=%b held=%b expected %b/%b",
               action_pulse, action_held, 6'b000001, 6'b000001);
    end
    applyStimulus(64'h0);
    waitCycles(3);
    baseRight = pulseTotal[1];
    applyStimulus(64'h0000_0000_0007_0004);
    waitCycles(2);
    checks++;
    if (action_pulse !== 6'b000001 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL conflict_tie pulse=%b held=%b expected %b/%b",
               action_pulse, action_held, 6'b000001, 6'b000001);
    end
    waitCycles(3);
    checks++;
    if (pulseTotal[1] - baseRight !== 0) begin
      errors++;
      $display("[TB] FAIL conflict_tie_right count=%0d expected=0", pulseTotal[1] - baseRight);
    end
    releaseAll();
  endtask

  task automatic test_rollover();
    int base;
    applyStimulus(64'h07);
    waitCycles(4);
    base = pulseTotal[1];
    applyStimulus(64'h0101_0101_0101_0101);
    waitCycles(3);
    checks++;
    if (action_held !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL rollover_held actual=%b expected=%b", action_held, 6'b000010);
    end
    applyStimulus(64'h07);
    waitCycles(3);
    checks++;
    if (pulseTotal[1] - base !== 0 || action_held !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL rollover_no_pulse count=%0d held=%b expected 0/%b",
               pulseTotal[1] - base, action_held, 6'b000010);
    end
    releaseAll();
  endtask

  task automatic test_release_tick();
    int base;
    base = pulseTotal[0];
    applyStimulus(64'h04);
    waitCycles(3);
    for (int t = 0; t < 9; t++) frameTick();
    checks++;
    if (pulseTotal[0] - base !== 1) begin
      errors++;
      $display("[TB] FAIL reltick_before count=%0d expected=1", pulseTotal[0] - base);
    end
    // Release lands in stage 1 on the same edge the 10th tick is registered
    frame_sync = 1'b1;
    waitCycles(2);
    applyStimulus(64'h0);
    waitCycles(2);
    frame_sync = 1'b0;
    waitCycles(4);
    checks++;
    if (pulseTotal[0] - base !== 1 || action_held !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reltick_release_wins count=%0d held=%b expected 1/%b",
               pulseTotal[0] - base, action_held, 6'b0);
    end
    releaseAll();
  endtask

  task automatic test_enable();
    int base;
    base = pulseTotal[0];
    applyStimulus(64'h04);
    waitCycles(3);
    for (int t = 0; t < 11; t++) frameTick();
    checks++;
    if (pulseTotal[0] - base !== 2 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL enable_repeat count=%0d held=%b expected 2/%b",
               pulseTotal[0] - base, action_held, 6'b000001);
    end
    enable = 1'b0;
    waitCycles(1);
    checks++;
    if (action_held !== 6'b0 || action_pulse !== 6'b0) begin
      errors++;
      $display("[TB] FAIL enable_low pulse=%b held=%b expected 0/0", action_pulse, action_held);
    end
    frameTick();
    frameTick();
    checks++;
    if (pulseTotal[0] - base !== 2 || action_held !== 6'b0) begin
      errors++;
      $display("[TB] FAIL enable_paused count=%0d held=%b expected 2/%b",
               pulseTotal[0] - base, action_held, 6'b0);
    end
    enable = 1'b1;
    waitCycles(1);
    checks++;
    if (action_pulse !== 6'b000001 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL enable_resume pulse=%b held=%b expected %b/%b",
               action_pulse, action_held, 6'b000001, 6'b000001);
    end
    releaseAll();
  endtask

  task automatic test_async_reset();
    applyStimulus(64'h04);
    waitCycles(3);
    for (int t = 0; t < 11; t++) frameTick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (action_held !== 6'b0 || action_pulse !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_immediate pulse=%b held=%b expected 0/0",
               action_pulse, action_held);
    end
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(1);
    checks++;
    if (action_pulse !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_stage1 actual=%b expected=%b", action_pulse, 6'b0);
    end
    waitCycles(1);
    checks++;
    if (action_pulse !== 6'b000001 || action_held !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL async_reset_fresh pulse=%b held=%b expected %b/%b",
               action_pulse, action_held, 6'b000001, 6'b000001);
    end
    releaseAll();
  endtask

  initial begin
    test_reset();
    test_das_arr();
    test_oneshot();
    test_conflict();
    test_rollover();
    test_release_tick();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
